serdes_link_emu: RTL and testbench



---
 rtl/link_emu_pkg.sv | 21 ++
 rtl/link_emu_delay.sv | 30 +++
 rtl/serdes_link_emu.sv | 171 +++++++++++++++++
 tb/tb_serdes_link_emu.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_emu_pkg.sv
// Shared types and constants for the SERDES link emulator.
package link_emu_pkg;

  // Injection schedule states.
  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    BURST,
    GAP,
    DONE
  } emu_state_e;

  // 64b/66b sync header values.
  localparam logic [1:0] HDR_DATA    = 2'b01;
  localparam logic [1:0] HDR_CTRL    = 2'b10;
  localparam logic [1:0] HDR_INVALID = 2'b00;

  // Deepest supported delay line.
  localparam int DELAY_MAX = 16;

endpackage

// File: rtl/link_emu_delay.sv
// Fixed-depth block delay line with a synchronous, active-low zeroing reset.
module link_emu_delay #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 6
) (
  input  logic             tx_clk,
  input  logic             tx_rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift one stage per cycle; reset flushes every stage.
  always_ff @(posedge tx_clk) begin
    if (!tx_rst) begin
      // NOTE: every stage is cleared on reset, not just the last one, so no
      // pre-reset block can leak out of the line after reset is released.
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage read its neighbour's
      // old value, which is what turns this loop into a shift register.
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/serdes_link_emu.sv
// SERDES TX channel model: fixed block delay plus scheduled sync-header
// corruption with a saturating injection counter.
// Optional build macro LINK_EMU_BITFLIP_EN adds payload bit flips during
// bursts (cfg_flip_mask input, flip_count output).
module serdes_link_emu
  import link_emu_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2,
  parameter int DELAY      = 6,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  tx_clk,
  input  logic                  tx_rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [HDR_WIDTH-1:0]  in_hdr,
  input  logic                  cfg_corrupt_en,
  input  logic [HDR_WIDTH-1:0]  cfg_corrupt_hdr,
  input  logic [CNT_WIDTH-1:0]  cfg_corrupt_start,
  input  logic [CNT_WIDTH-1:0]  cfg_corrupt_len,
  input  logic [CNT_WIDTH-1:0]  cfg_corrupt_period,
  input  logic                  cfg_count_clr,
`ifdef LINK_EMU_BITFLIP_EN
  input  logic [DATA_WIDTH-1:0] cfg_flip_mask,
  output logic [CNT_WIDTH-1:0]  flip_count,
`endif
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [HDR_WIDTH-1:0]  out_hdr,
  output logic                  corrupt_active,
  output logic                  corrupt_done,
  output logic [CNT_WIDTH-1:0]  corrupt_count
);

  // Out-of-range depths are clamped into 1..DELAY_MAX.
  localparam int DEPTH = (DELAY > DELAY_MAX) ? DELAY_MAX : ((DELAY < 1) ? 1 : DELAY);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] dly_data;
  logic [HDR_WIDTH-1:0]  dly_hdr;

  emu_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 cfg_load;
  logic                 burst_hit;

  logic [CNT_WIDTH-1:0] len_q;
  logic [CNT_WIDTH-1:0] period_q;
  logic [HDR_WIDTH-1:0] hdr_q;
`ifdef LINK_EMU_BITFLIP_EN
  logic [DATA_WIDTH-1:0] mask_q;
`endif

  link_emu_delay #(
    .WIDTH (DATA_WIDTH + HDR_WIDTH),
    .DEPTH (DEPTH)
  ) u_delay (
    .tx_clk (tx_clk),
    .tx_rst (tx_rst),
    .d      ({in_data, in_hdr}),
    .q      ({dly_data, dly_hdr})
  );

  // Schedule next-state and counter reload; dropping enable wins everywhere.
  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch
    // is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    cfg_load = 1'b0;
    if (!cfg_corrupt_en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          cfg_load = 1'b1;
          if (cfg_corrupt_len == '0) begin
            state_d = DONE;
          end else if (cfg_corrupt_start == '0) begin
            state_d = BURST;
            cnt_d   = cfg_corrupt_len - CNT_ONE;
          end else begin
            state_d = WAIT;
            cnt_d   = cfg_corrupt_start - CNT_ONE;
          end
        end
        WAIT, GAP: begin
          if (cnt_q == '0) begin
            state_d = BURST;
            cnt_d   = len_q - CNT_ONE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        BURST: begin
          if (cnt_q == '0) begin
            if (period_q == '0) begin
              state_d = DONE;
            end else begin
              state_d = GAP;
              cnt_d   = period_q - CNT_ONE;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // A BURST cycle only corrupts if enable is still held on that edge.
  assign burst_hit = (state_q == BURST) && cfg_corrupt_en;

  // Schedule state, counter and configuration snapshot taken on leaving IDLE.
  always_ff @(posedge tx_clk) begin
    if (!tx_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      period_q <= '0;
      hdr_q    <= '0;
`ifdef LINK_EMU_BITFLIP_EN
      mask_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cfg_load) begin
        len_q    <= cfg_corrupt_len;
        period_q <= cfg_corrupt_period;
        hdr_q    <= cfg_corrupt_hdr;
`ifdef LINK_EMU_BITFLIP_EN
        mask_q   <= cfg_flip_mask;
`endif
      end
    end
  end

  // Substitution flag aligned with the final delay stage, plus saturating counters.
  always_ff @(posedge tx_clk) begin
    if (!tx_rst) begin
      corrupt_active <= 1'b0;
      corrupt_count  <= '0;
`ifdef LINK_EMU_BITFLIP_EN
      flip_count     <= '0;
`endif
    end else begin
      corrupt_active <= burst_hit;
      if (cfg_count_clr)
        corrupt_count <= '0;
      else if (burst_hit && (corrupt_count != '1))
        corrupt_count <= corrupt_count + CNT_ONE;
`ifdef LINK_EMU_BITFLIP_EN
      if (cfg_count_clr)
        flip_count <= '0;
      else if (burst_hit && (mask_q != '0) && (flip_count != '1))
        flip_count <= flip_count + CNT_ONE;
`endif
    end
  end

  assign corrupt_done = (state_q == DONE);
  assign out_hdr      = corrupt_active ? hdr_q : dly_hdr;
`ifdef LINK_EMU_BITFLIP_EN
  assign out_data     = corrupt_active ? (dly_data ^ mask_q) : dly_data;
`else
  assign out_data     = dly_data;
`endif

endmodule

// File: tb/tb_serdes_link_emu.sv
// Scoreboard bench for serdes_link_emu: stimulus pushes model expectations,
// a monitor pops and compares once per cycle on the falling edge.
module tb_serdes_link_emu;
  import link_emu_pkg::*;

  localparam int DW    = 64;
  localparam int HW    = 2;
  localparam int DELAY = 6;
  // Narrow counters so saturation is reachable in a short run.
  localparam int CW    = 8;
  localparam int CMAX  = (1 << CW) - 1;

  logic          tx_clk = 1'b0;
  logic          tx_rst = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [HW-1:0] in_hdr = '0;
  logic          cfg_corrupt_en = 1'b0;
  logic [HW-1:0] cfg_corrupt_hdr = '0;
  logic [CW-1:0] cfg_corrupt_start = '0;
  logic [CW-1:0] cfg_corrupt_len = '0;
  logic [CW-1:0] cfg_corrupt_period = '0;
  logic          cfg_count_clr = 1'b0;
  logic [DW-1:0] out_data;
  logic [HW-1:0] out_hdr;
  logic          corrupt_active;
  logic          corrupt_done;
  logic [CW-1:0] corrupt_count;
`ifdef LINK_EMU_BITFLIP_EN
  logic [DW-1:0] cfg_flip_mask = '0;
  logic [CW-1:0] flip_count;
`endif

  serdes_link_emu #(
    .DATA_WIDTH (DW),
    .HDR_WIDTH  (HW),
    .DELAY      (DELAY),
    .CNT_WIDTH  (CW)
  ) dut (
    .tx_clk             (tx_clk),
    .tx_rst             (tx_rst),
    .in_data            (in_data),
    .in_hdr             (in_hdr),
    .cfg_corrupt_en     (cfg_corrupt_en),
    .cfg_corrupt_hdr    (cfg_corrupt_hdr),
    .cfg_corrupt_start  (cfg_corrupt_start),
    .cfg_corrupt_len    (cfg_corrupt_len),
    .cfg_corrupt_period (cfg_corrupt_period),
    .cfg_count_clr      (cfg_count_clr),
`ifdef LINK_EMU_BITFLIP_EN
    .cfg_flip_mask      (cfg_flip_mask),
    .flip_count         (flip_count),
`endif
    .out_data           (out_data),
    .out_hdr            (out_hdr),
    .corrupt_active     (corrupt_active),
    .corrupt_done       (corrupt_done),
    .corrupt_count      (corrupt_count)
  );

  always #5 tx_clk = ~tx_clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [HW-1:0] hdr;
  } blk_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [HW-1:0] hdr;
    logic          active;
    logic          done;
    logic [CW-1:0] count;
    logic [CW-1:0] flips;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: wire contents as a queue, schedule as elapsed time
  // since enable was accepted, folded over one burst+gap window.
  blk_t          m_pipe[$];
  bit            m_on, m_done, m_hit;
  int            m_k, m_start, m_len, m_period, m_count, m_flips;
  logic [HW-1:0] m_hdr;
  logic [DW-1:0] m_mask;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Advance the model over the coming edge, queue its prediction, take the edge.
  task automatic step();
    blk_t b;
    exp_t e;
    int   t;
    if (!tx_rst) begin
      foreach (m_pipe[i]) m_pipe[i] = '0;
      m_on = 0; m_done = 0; m_hit = 0; m_count = 0; m_flips = 0;
    end else begin
      b.data = in_data;
      b.hdr  = in_hdr;
      m_pipe.push_front(b);
      void'(m_pipe.pop_back());
      m_hit = 0;
      if (!cfg_corrupt_en) begin
        m_on = 0; m_done = 0;
      end else if (!m_on) begin
        m_on     = 1;
        m_k      = 0;
        m_start  = int'(cfg_corrupt_start);
        m_len    = int'(cfg_corrupt_len);
        m_period = int'(cfg_corrupt_period);
        m_hdr    = cfg_corrupt_hdr;
`ifdef LINK_EMU_BITFLIP_EN
        m_mask   = cfg_flip_mask;
`else
        m_mask   = '0;
`endif
        m_done   = (m_len == 0);
      end else begin
        m_k++;
        if (!m_done) begin
          t = m_k - 1 - m_start;
          if (t >= 0)
            m_hit = (m_period == 0) ? (t < m_len) : ((t % (m_len + m_period)) < m_len);
          if (m_period == 0 && m_k >= m_start + m_len) m_done = 1;
        end
      end
      if (cfg_count_clr) m_count = 0;
      else if (m_hit && m_count < CMAX) m_count++;
      if (cfg_count_clr) m_flips = 0;
      else if (m_hit && m_mask != '0 && m_flips < CMAX) m_flips++;
    end
    b        = m_pipe[DELAY-1];
    e.data   = m_hit ? (b.data ^ m_mask) : b.data;
    e.hdr    = m_hit ? m_hdr : b.hdr;
    e.active = m_hit;
    e.done   = m_done;
    e.count  = CW'(m_count);
    e.flips  = CW'(m_flips);
    exp_q.push_back(e);
    @(posedge tx_clk);
    #1;
  endtask

  task automatic rand_block();
    in_data = {$urandom, $urandom};
    in_hdr  = ($urandom_range(0, 1) != 0) ? HDR_DATA : HDR_CTRL;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      rand_block();
      step();
    end
  endtask

  task automatic set_cfg(input int start, input int len, input int period, input logic [HW-1:0] hdr);
    cfg_corrupt_start  = CW'(start);
    cfg_corrupt_len    = CW'(len);
    cfg_corrupt_period = CW'(period);
    cfg_corrupt_hdr    = hdr;
`ifdef LINK_EMU_BITFLIP_EN
    cfg_flip_mask      = ($urandom_range(0, 3) == 0) ? '0 : {$urandom, $urandom};
`endif
  endtask

  task automatic pulse_clr();
    cfg_count_clr = 1'b1;
    run(1);
    cfg_count_clr = 1'b0;
  endtask

  // Monitor: one comparison set per falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge tx_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_data",       64'(out_data),       64'(e.data));
        check("out_hdr",        64'(out_hdr),        64'(e.hdr));
        check("corrupt_active", 64'(corrupt_active), 64'(e.active));
        check("corrupt_done",   64'(corrupt_done),   64'(e.done));
        check("corrupt_count",  64'(corrupt_count),  64'(e.count));
`ifdef LINK_EMU_BITFLIP_EN
        check("flip_count",     64'(flip_count),     64'(e.flips));
`endif
      end
    end
  end

  initial begin
    logic [63:0] pat [6];
    pat[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    pat[1] = 64'h0000_0000_0000_0000;
    pat[2] = 64'h5555_5555_5555_5555;
    pat[3] = 64'hAAAA_AAAA_AAAA_AAAA;
    pat[4] = 64'hFEFE_FEFE_FEFE_FEFE;
    pat[5] = 64'h0707_0707_0707_0707;
    for (int i = 0; i < DELAY; i++) m_pipe.push_back('0);

    // Reset held, then released with a control-header pattern rotation.
    tx_rst = 1'b0;
    run(3);
    tx_rst = 1'b1;
    for (int i = 0; i < 24; i++) begin
      in_data = pat[i % 6];
      in_hdr  = HDR_CTRL;
      step();
    end

    // One-shot: start=10, len=5, invalid header substitution.
    set_cfg(10, 5, 0, HDR_INVALID);
    cfg_corrupt_en = 1'b1;
    run(30);
    cfg_corrupt_en = 1'b0;
    run(2);

    // Periodic: 2 corrupted / 3 clean, count cleared first.
    pulse_clr();
    set_cfg(0, 2, 3, 2'b11);
    cfg_corrupt_en = 1'b1;
    run(50);
    cfg_corrupt_en = 1'b0;
    run(2);

    // Burst truncated by dropping enable.
    pulse_clr();
    set_cfg(0, 8, 0, 2'b11);
    cfg_corrupt_en = 1'b1;
    run(3);
    cfg_corrupt_en = 1'b0;
    run(3);

    // Saturation with a clear pulse while bursting.
    set_cfg(0, 15, 1, HDR_INVALID);
    cfg_corrupt_en = 1'b1;
    run(20);
    pulse_clr();
    run(380);
    cfg_corrupt_en = 1'b0;
    run(2);

    // Reset mid-burst with enable held: schedule restarts from IDLE.
    pulse_clr();
    set_cfg(0, 8, 0, 2'b11);
    cfg_corrupt_en = 1'b1;
    run(3);
    tx_rst = 1'b0;
    run(1);
    tx_rst = 1'b1;
    run(12);
    cfg_corrupt_en = 1'b0;
    run(2);

    // Randomised schedules with mid-schedule cfg changes and stray clears.
    for (int r = 0; r < 25; r++) begin
      int n_on;
      set_cfg($urandom_range(0, 12), $urandom_range(0, 6), $urandom_range(0, 5), HW'($urandom));
      cfg_corrupt_en = 1'b1;
      n_on = $urandom_range(5, 60);
      for (int i = 0; i < n_on; i++) begin
        if ($urandom_range(0, 15) == 0)
          set_cfg($urandom_range(0, 12), $urandom_range(0, 6), $urandom_range(0, 5), HW'($urandom));
        cfg_count_clr = ($urandom_range(0, 40) == 0);
        run(1);
      end
      cfg_count_clr  = 1'b0;
      cfg_corrupt_en = 1'b0;
      run($urandom_range(1, 3));
    end

    @(negedge tx_clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
